// File: rtl/ex_mem_buffer.sv
// rtl/ex_mem_buffer.sv - execute->memory stage buffer with in-order flag commit and halt sequencing
//
// Purpose:
//   Small FIFO between the ALU compute stage and the memory stage. Each accepted
//   instruction carries its ALU result, effective address, store data and
//   writeback control. The architectural {Z,V,N} flag register is updated as
//   entries leave, so flag changes follow program order. An accepted HLT closes
//   the input side; the block reports halted once the HLT entry has been popped.
//
// Configuration:
//   FLAG_BYPASS_EN - when defined, flags_zvn shows the post-commit value in the
//                    same cycle as a committing pop; otherwise it shows only
//                    the flag register.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       execute-side handshake
//   in_opcode .. in_alu_n     instruction fields from the execute stage
//   flush                     drop every buffered entry and the current input
//   out_valid / out_ready     memory-side handshake
//   out_opcode .. out_wr_en   head entry fields
//   flags_zvn                 architectural flags {Z,V,N}
//   halted                    HLT has retired

module ex_mem_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_mem_addr,
    input  logic [DATA_W-1:0] in_st_data,
    input  logic [3:0]        in_dst_reg,
    input  logic              in_wr_en,
    input  logic              in_alu_v,
    input  logic              in_alu_n,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [DATA_W-1:0] out_alu_out,
    output logic [DATA_W-1:0] out_mem_addr,
    output logic [DATA_W-1:0] out_st_data,
    output logic [3:0]        out_dst_reg,
    output logic              out_wr_en,
    output logic [2:0]        flags_zvn,
    output logic              halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRA = 4'h5;
    localparam logic [3:0] OP_ROR = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t state;

    logic [3:0]        opcode_q  [DEPTH];
    logic [DATA_W-1:0] alu_out_q [DEPTH];
    logic [DATA_W-1:0] mem_addr_q[DEPTH];
    logic [DATA_W-1:0] st_data_q [DEPTH];
    logic [3:0]        dst_reg_q [DEPTH];
    logic              wr_en_q   [DEPTH];
    logic              z_q       [DEPTH];
    logic              v_q       [DEPTH];
    logic              n_q       [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [2:0]    flags_q;
    logic [2:0]    flags_next;
    logic          accept;
    logic          pop;

    assign out_valid = (count != '0);
    assign in_ready  = (count < CW'(DEPTH)) && (state == RUN);
    assign accept    = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign halted    = (state == HALTED);

    assign out_opcode   = opcode_q[rd_ptr];
    assign out_alu_out  = alu_out_q[rd_ptr];
    assign out_mem_addr = mem_addr_q[rd_ptr];
    assign out_st_data  = st_data_q[rd_ptr];
    assign out_dst_reg  = dst_reg_q[rd_ptr];
    assign out_wr_en    = wr_en_q[rd_ptr];

    // Flag value that the head entry would commit if it popped now.
    always_comb begin
        flags_next = flags_q;
        case (opcode_q[rd_ptr])
            OP_ADD, OP_SUB: flags_next = {z_q[rd_ptr], v_q[rd_ptr], n_q[rd_ptr]};
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_next[2] = z_q[rd_ptr];
            default: flags_next = flags_q;
        endcase
    end

`ifdef FLAG_BYPASS_EN
    assign flags_zvn = pop ? flags_next : flags_q;
`else
    assign flags_zvn = flags_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            flags_q <= 3'b000;
            // Storage is cleared so the head fields read zero out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                opcode_q[i]   <= '0;
                alu_out_q[i]  <= '0;
                mem_addr_q[i] <= '0;
                st_data_q[i]  <= '0;
                dst_reg_q[i]  <= '0;
                wr_en_q[i]    <= 1'b0;
                z_q[i]        <= 1'b0;
                v_q[i]        <= 1'b0;
                n_q[i]        <= 1'b0;
            end
        end else if (flush && state != HALTED) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // In DRAIN the HLT is necessarily still buffered, so flushing it
            // reopens the input side.
            if (state == DRAIN) begin
                state <= RUN;
            end
        end else begin
            if (accept) begin
                opcode_q[wr_ptr]   <= in_opcode;
                alu_out_q[wr_ptr]  <= in_alu_out;
                mem_addr_q[wr_ptr] <= in_mem_addr;
                st_data_q[wr_ptr]  <= in_st_data;
                dst_reg_q[wr_ptr]  <= in_dst_reg;
                wr_en_q[wr_ptr]    <= in_wr_en;
                z_q[wr_ptr]        <= (in_alu_out == '0);
                v_q[wr_ptr]        <= in_alu_v;
                n_q[wr_ptr]        <= in_alu_n;
                wr_ptr             <= wr_ptr + AW'(1);
                if (in_opcode == OP_HLT) begin
                    state <= DRAIN;
                end
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                flags_q <= flags_next;
                if (opcode_q[rd_ptr] == OP_HLT) begin
                    state <= HALTED;
                end
            end
            count <= count + CW'(accept) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_ex_mem_buffer.sv
// tb/tb_ex_mem_buffer.sv - self-checking bench for ex_mem_buffer against a queue-based model

module tb_ex_mem_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [DATA_W-1:0] in_alu_out;
    logic [DATA_W-1:0] in_mem_addr;
    logic [DATA_W-1:0] in_st_data;
    logic [3:0]        in_dst_reg;
    logic              in_wr_en;
    logic              in_alu_v;
    logic              in_alu_n;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_opcode;
    logic [DATA_W-1:0] out_alu_out;
    logic [DATA_W-1:0] out_mem_addr;
    logic [DATA_W-1:0] out_st_data;
    logic [3:0]        out_dst_reg;
    logic              out_wr_en;
    logic [2:0]        flags_zvn;
    logic              halted;

    ex_mem_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_alu_out  (in_alu_out),
        .in_mem_addr (in_mem_addr),
        .in_st_data  (in_st_data),
        .in_dst_reg  (in_dst_reg),
        .in_wr_en    (in_wr_en),
        .in_alu_v    (in_alu_v),
        .in_alu_n    (in_alu_n),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_alu_out (out_alu_out),
        .out_mem_addr(out_mem_addr),
        .out_st_data (out_st_data),
        .out_dst_reg (out_dst_reg),
        .out_wr_en   (out_wr_en),
        .flags_zvn   (flags_zvn),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        op;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] st;
        logic [3:0]        dst;
        logic              wr;
        logic              v;
        logic              n;
    } entry_t;

    entry_t     q[$];
    logic [2:0] m_flags;
    int         m_state;   // 0 run, 1 draining, 2 halted
    int         n_tests = 0;
    int         n_fail  = 0;
`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flags after retiring entry e: arithmetic sets all three, logic/shift only Z.
    function automatic logic [2:0] retire_flags(input entry_t e, input logic [2:0] old);
        logic z;
        z = (e.alu == 0);
        if (e.op == 4'h0 || e.op == 4'h1) return {z, e.v, e.n};
        if (e.op == 4'h2 || e.op == 4'h4 || e.op == 4'h5 || e.op == 4'h6) return {z, old[1:0]};
        return old;
    endfunction

    // Compares outputs against the model mid-cycle, then advances one clock.
    task automatic step();
        bit         acc;
        bit         pp;
        entry_t     e;
        logic [2:0] ef;
        #1;
        acc = in_valid && (q.size() < DEPTH) && (m_state == 0) && !flush;
        pp  = (q.size() > 0) && out_ready && !flush;
        check("in_ready", in_ready, (q.size() < DEPTH) && (m_state == 0));
        check("out_valid", out_valid, q.size() > 0);
        check("halted", halted, m_state == 2);
        ef = m_flags;
        if (q.size() > 0) begin
            check("out_opcode", out_opcode, q[0].op);
            check("out_alu_out", out_alu_out, q[0].alu);
            check("out_mem_addr", out_mem_addr, q[0].addr);
            check("out_st_data", out_st_data, q[0].st);
            check("out_dst_reg", out_dst_reg, q[0].dst);
            check("out_wr_en", out_wr_en, q[0].wr);
            if (BYPASS && pp) ef = retire_flags(q[0], m_flags);
        end
        check("flags_zvn", flags_zvn, ef);
        e.op = in_opcode; e.alu = in_alu_out; e.addr = in_mem_addr; e.st = in_st_data;
        e.dst = in_dst_reg; e.wr = in_wr_en; e.v = in_alu_v; e.n = in_alu_n;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_flags = 3'b000;
            m_state = 0;
        end else if (flush && m_state != 2) begin
            q.delete();
            if (m_state == 1) m_state = 0;
        end else begin
            if (pp) begin
                m_flags = retire_flags(q[0], m_flags);
                if (q[0].op == 4'hF) m_state = 2;
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(e);
                if (e.op == 4'hF) m_state = 1;
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [DATA_W-1:0] alu,
                         input bit vv, input bit nn, input bit ordy, input bit fl);
        rst         = 1'b0;
        in_valid    = v;
        in_opcode   = op;
        in_alu_out  = alu;
        in_mem_addr = DATA_W'($urandom);
        in_st_data  = DATA_W'($urandom);
        in_dst_reg  = 4'($urandom);
        in_wr_en    = 1'($urandom);
        in_alu_v    = vv;
        in_alu_n    = nn;
        out_ready   = ordy;
        flush       = fl;
    endtask

    task automatic do_reset();
        drive(0, 4'h0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [2:0] saved_flags;
    int         halt_cycles;
    int         guard;

    initial begin
        drive(0, 4'h0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        m_flags = 3'b000;
        m_state = 0;

        // Reset values
        check("rst_out_alu_out", out_alu_out, 0);
        check("rst_out_opcode", out_opcode, 0);
        check("rst_out_wr_en", out_wr_en, 0);
        check("rst_flags", flags_zvn, 3'b000);
        step();

        // ADD of zero with overflow, popped immediately
        drive(1, 4'h0, 16'h0000, 1, 0, 1, 0);
        step();
        drive(0, 4'h0, 16'h1234, 0, 0, 1, 0);
        #1;
        check("t1_out_valid", out_valid, 1);
        check("t7_pop_cycle_flags", flags_zvn, BYPASS ? 3'b110 : 3'b000);
        step();
        check("t1_flags", flags_zvn, 3'b110);

        // XOR non-zero after flags=111 clears only Z
        drive(1, 4'h0, 16'h0000, 1, 1, 1, 0);
        step();
        drive(0, 4'h0, 16'h1, 0, 0, 1, 0);
        step();
        check("t2_pre_flags", flags_zvn, 3'b111);
        drive(1, 4'h2, 16'h8001, 0, 0, 1, 0);
        step();
        drive(0, 4'h0, 16'h1, 0, 0, 1, 0);
        step();
        check("t2_flags", flags_zvn, 3'b011);

        // Fill with out_ready low; third is held, then full+pop
        drive(1, 4'h8, 16'h0101, 0, 0, 0, 0); step();
        drive(1, 4'h9, 16'h0202, 0, 0, 0, 0); step();
        drive(1, 4'h0, 16'h0303, 0, 1, 0, 0);
        #1;
        check("t3_full_in_ready", in_ready, 0);
        step();
        step();
        out_ready = 1'b1;
        #1;
        check("t4_full_in_ready", in_ready, 0);
        step();
        check("t4_after_pop_in_ready", in_ready, 1);
        step();
        drive(0, 4'h0, 16'h1, 0, 0, 1, 0);
        repeat (3) step();

        // Flush with SUB + LW buffered
        saved_flags = m_flags;
        drive(1, 4'h1, 16'h0000, 1, 1, 0, 0); step();
        drive(1, 4'h8, 16'h0040, 0, 0, 0, 0); step();
        drive(0, 4'h0, 16'h1, 0, 0, 1, 1); step();
        check("t5_out_valid", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        check("t5_flags", flags_zvn, saved_flags);
        drive(0, 4'h0, 16'h1, 0, 0, 1, 0); step();

        // HLT behind SW
        drive(1, 4'h9, 16'h0010, 0, 0, 0, 0); step();
        drive(1, 4'hF, 16'h0000, 0, 0, 0, 0); step();
        check("t6_in_ready", in_ready, 0);
        drive(1, 4'h0, 16'h0000, 1, 1, 1, 0);
        guard = 0;
        while (m_state != 2 && guard < 10) begin
            step();
            guard++;
        end
        check("t6_halt_reached", m_state == 2 && guard < 10, 1);
        repeat (3) step();
        check("t6_halted_sticky", halted, 1);
        check("t6_in_ready_halted", in_ready, 0);

        // Randomized traffic
        do_reset();
        halt_cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = ($urandom_range(99) < 4) ? 4'hF : 4'($urandom_range(14));
            drive($urandom_range(99) < 70, op,
                  ($urandom_range(3) == 0) ? 16'h0000 : DATA_W'($urandom),
                  1'($urandom), 1'($urandom),
                  $urandom_range(99) < 60, $urandom_range(99) < 5);
            halt_cycles = (m_state == 2) ? halt_cycles + 1 : 0;
            if ($urandom_range(99) < 2 || halt_cycles > 6) rst = 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
